// File: rtl/sine_pkg.sv
// Shared constants and types for the sine generator / analyser path.
//   SINE_SIZE  - width of a sine sample (unsigned, mid-scale = 2^(SINE_SIZE-1))
//   TABLE_SIZE - entries in the half-sine lookup table
//   PHASE_SIZE - width of the generator phase accumulator
//   analyser_state_t - lock state of the sine_wave_analyser
package sine_pkg;

    localparam int SINE_SIZE  = 8;
    localparam int TABLE_SIZE = 256;
    localparam int PHASE_SIZE = 10;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } analyser_state_t;

endpackage

// File: rtl/hyst_crossing_detector.sv
// Hysteresis comparator around mid-scale.
// Arms when a sample falls below MID-HYST and fires a crossing event on the
// first armed sample at or above MID+HYST. Samples inside the band leave the
// armed flag untouched, so noise around mid-scale cannot produce events.
// Ports:
//   clock, reset_n   - clock and asynchronous active-low reset
//   sample           - unsigned input sample
//   sample_valid     - qualifier; armed only changes on valid samples
//   clear            - disarm on the next valid sample (used on timeout)
//   cross_evt        - combinational crossing event for the current sample
module hyst_crossing_detector
    import sine_pkg::*;
#(
    parameter int SINE_SIZE = sine_pkg::SINE_SIZE,
    parameter int MID       = 2 ** (SINE_SIZE - 1),
    parameter int HYST      = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [SINE_SIZE-1:0] sample,
    input  logic                 sample_valid,
    input  logic                 clear,
    output logic                 cross_evt
);

    localparam logic [SINE_SIZE-1:0] LO_THR = SINE_SIZE'(MID - HYST);
    localparam logic [SINE_SIZE-1:0] HI_THR = SINE_SIZE'(MID + HYST);

    logic armed;

    assign cross_evt = sample_valid && armed && (sample >= HI_THR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            armed <= 1'b0;
        end else if (sample_valid) begin
            if (clear || cross_evt) begin
                armed <= 1'b0;
            end else if (sample < LO_THR) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sine_wave_analyser.sv
// Receive-side analyser for a stream of unsigned sine samples.
// Detects rising mid-crossings with hysteresis, measures the period in
// samples together with peak, trough and amplitude over each period, and
// declares lock once consecutive periods agree within TOL.
// Ports:
//   clock, reset_n    - clock and asynchronous active-low reset
//   sample            - unsigned sample, qualified by sample_valid
//   sample_valid      - all state advances only when high
//   crossing          - one-cycle pulse after a rising crossing sample
//   meas_valid        - one-cycle pulse when period/peak/trough/amplitude update
//   period            - samples between the last two rising crossings
//   peak, trough      - max / min sample over the last measured period
//   amplitude         - peak minus trough
//   sample_index      - valid samples since the last crossing
//   locked            - period is stable
module sine_wave_analyser
    import sine_pkg::*;
#(
    parameter int SINE_SIZE  = sine_pkg::SINE_SIZE,
    parameter int MID        = 2 ** (SINE_SIZE - 1),
    parameter int HYST       = 4,
    parameter int PERIOD_W   = 16,
    parameter int TOL        = 2,
    parameter int LOCK_COUNT = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [SINE_SIZE-1:0] sample,
    input  logic                 sample_valid,
    output logic                 crossing,
    output logic                 meas_valid,
    output logic [PERIOD_W-1:0]  period,
    output logic [SINE_SIZE-1:0] peak,
    output logic [SINE_SIZE-1:0] trough,
    output logic [SINE_SIZE-1:0] amplitude,
    output logic [PERIOD_W-1:0]  sample_index,
    output logic                 locked
);

    localparam int SC_W = $clog2(LOCK_COUNT + 1);

    function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [PERIOD_W:0] abs_diff(input logic signed [PERIOD_W:0] d);
        return (d < 0) ? $unsigned(-d) : $unsigned(d);
    endfunction

    analyser_state_t         state, state_next;
    logic [SC_W-1:0]         stable_cnt, stable_next, stable_inc;
    logic                    locked_next;
    logic [SINE_SIZE-1:0]    run_max, run_min;
    logic                    cross_evt;
    logic                    timeout;
    logic                    cross_fire;
    logic                    meas_fire;
    logic signed [PERIOD_W:0] period_diff;
    logic                    in_tol;

    hyst_crossing_detector #(
        .SINE_SIZE (SINE_SIZE),
        .MID       (MID),
        .HYST      (HYST)
    ) u_detector (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample       (sample),
        .sample_valid (sample_valid),
        .clear        (timeout),
        .cross_evt    (cross_evt)
    );

    // Event decode. A saturated index while measuring means the waveform
    // has gone away; timeout wins over a coincident crossing.
    always_comb begin
        timeout     = sample_valid && (state != ACQUIRE) && (sample_index == '1);
        cross_fire  = cross_evt && !timeout;
        meas_fire   = cross_fire && (state != ACQUIRE);
        period_diff = $signed({1'b0, sample_index}) - $signed({1'b0, period});
        // A zero previous period marks the first measurement after ACQUIRE.
        in_tol      = (period != '0) && (abs_diff(period_diff) <= (PERIOD_W + 1)'(TOL));
        stable_inc  = stable_cnt + 1'b1;
    end

    // Next-state logic
    always_comb begin
        state_next  = state;
        stable_next = stable_cnt;
        locked_next = locked;
        if (timeout) begin
            state_next  = ACQUIRE;
            stable_next = '0;
            locked_next = 1'b0;
        end else if (cross_fire) begin
            unique case (state)
                ACQUIRE: begin
                    state_next = MEASURE;
                end
                MEASURE: begin
                    if (in_tol) begin
                        stable_next = stable_inc;
                        if (stable_inc >= SC_W'(LOCK_COUNT)) begin
                            state_next  = LOCKED;
                            locked_next = 1'b1;
                        end
                    end else begin
                        stable_next = '0;
                    end
                end
                LOCKED: begin
                    if (!in_tol) begin
                        state_next  = MEASURE;
                        stable_next = '0;
                        locked_next = 1'b0;
                    end
                end
                default: begin
                    state_next  = ACQUIRE;
                    stable_next = '0;
                    locked_next = 1'b0;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ACQUIRE;
            stable_cnt <= '0;
            locked     <= 1'b0;
        end else if (sample_valid) begin
            state      <= state_next;
            stable_cnt <= stable_next;
            locked     <= locked_next;
        end
    end

    // Registered strobes and measurement datapath
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crossing     <= 1'b0;
            meas_valid   <= 1'b0;
            period       <= '0;
            peak         <= '0;
            trough       <= '0;
            amplitude    <= '0;
            sample_index <= '0;
            run_max      <= '0;
            run_min      <= '1;
        end else begin
            crossing   <= cross_fire;
            meas_valid <= meas_fire;
            if (sample_valid) begin
                if (cross_fire) begin
                    // The crossing sample is index 0 of the new period.
                    sample_index <= PERIOD_W'(1);
                    run_max      <= sample;
                    run_min      <= sample;
                end else begin
                    sample_index <= sat_inc(sample_index);
                    if (sample > run_max) run_max <= sample;
                    if (sample < run_min) run_min <= sample;
                end
                if (meas_fire) begin
                    period    <= sample_index;
                    peak      <= run_max;
                    trough    <= run_min;
                    amplitude <= run_max - run_min;
                end else if (timeout) begin
                    period <= '0;
                end
            end
        end
    end

endmodule

// File: doc/sine_wave_analyser.md
Name: sine_wave_analyser

Overview:
- Receive end of the sine generator path. Consumes a stream of SINE_SIZE-bit unsigned samples, e.g. the output of the sine generator or an ADC capture of it.
- Uses a hysteresis comparator around mid-scale to detect rising mid-crossings. Measures period in samples, peak, trough and amplitude.
- Declares lock once the period is stable.
- Sits downstream of the sine source. Used to close the loop on phaseStep selection and to self-check generated waveforms.

Parameters:
- SINE_SIZE, 8, sample width.
- MID, 128, mid-scale threshold (2^(SINE_SIZE-1)).
- HYST, 4, hysteresis half-width in LSBs.
- PERIOD_W, 16, width of the period and sample counters.
- TOL, 2, allowed period deviation (samples) between consecutive periods.
- LOCK_COUNT, 2, consecutive in-tolerance periods required for lock.

Ports:
- clock, input, 1, system clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- sample, input, SINE_SIZE, unsigned sample.
- sample_valid, input, 1, sample qualifier; logic advances only when high.
- crossing, output, 1, one-cycle pulse on a detected rising mid-crossing.
- meas_valid, output, 1, one-cycle pulse when period/peak/trough/amplitude update.
- period, output, PERIOD_W, samples between the last two rising crossings.
- peak, output, SINE_SIZE, maximum sample over the last measured period.
- trough, output, SINE_SIZE, minimum sample over the last measured period.
- amplitude, output, SINE_SIZE, peak minus trough.
- sample_index, output, PERIOD_W, valid samples since the last crossing (phase position).
- locked, output, 1, period stable.

Behaviour:
- Reset (reset_n low, async): all outputs 0; state ACQUIRE; armed=0; counters 0; run_max=0; run_min=all-ones; stable_cnt=0.
- All registers update only on posedge clock with sample_valid=1. With sample_valid=0 everything holds, and crossing/meas_valid are 0.
- Hysteresis:
  - armed set when sample < MID-HYST.
  - Crossing event when armed=1 and sample >= MID+HYST; armed clears on the same edge.
  - Samples inside the band do not change armed.
- Crossing event registered: crossing pulses high on the cycle after the crossing sample edge (1-cycle latency). meas_valid has the same timing when a measurement is produced.
- sample_index:
  - Increments per valid sample and saturates at all-ones.
  - Reset to 1 on a crossing sample (the crossing sample is index 0 of the new period, counted as it passes).
- run_max/run_min:
  - Track over valid samples, including the crossing sample.
  - On a crossing they restart from the crossing sample value.
- States:
  - ACQUIRE: no reference crossing yet. On crossing -> MEASURE; sample_index restarts; no meas_valid.
  - MEASURE: on crossing:
    - period <= sample_index (value before restart); peak <= run_max; trough <= run_min; amplitude <= run_max-run_min; meas_valid pulses.
    - If |new period - previous period| <= TOL and previous period nonzero: stable_cnt++, else stable_cnt <= 0.
    - When stable_cnt reaches LOCK_COUNT -> LOCKED, locked <= 1.
  - LOCKED: same measurement update on each crossing. A period outside TOL -> MEASURE, locked <= 0, stable_cnt <= 0.
- Timeout: in MEASURE or LOCKED, sample_index saturating (all-ones) -> ACQUIRE. On timeout period <= 0, locked <= 0, armed <= 0, stable_cnt <= 0; peak, trough and amplitude hold.
- Period arithmetic:
  - Unsigned PERIOD_W.
  - Difference computed in PERIOD_W+1 bits, absolute value taken.
  - First measurement after ACQUIRE never counts as in-tolerance.
- Flat or DC input (never dropping below MID-HYST, or never reaching MID+HYST): no crossings ever; remains in ACQUIRE or times out to it.
- Asynchronous reset mid-period: immediate return to the reset values above; no partial measurement is emitted.

Decomposition:
- Shared package sine_pkg:
  - SINE_SIZE, TABLE_SIZE, PHASE_SIZE constants (shared with the generator and the half-sine table).
  - analyser_state_t enum {ACQUIRE, MEASURE, LOCKED}.
- One sub-module, hyst_crossing_detector: owns armed and produces the crossing-event strobe from sample, sample_valid, MID and HYST.
- Counters, min/max tracking and the FSM stay in sine_wave_analyser.

Test Plan:
- Reset: hold reset_n=0 with random samples -> all outputs 0, locked=0. Deassert, then sample_valid=0 for 10 cycles -> outputs unchanged.
- Square stimulus 0,0,0,0,255,255,255,255 repeated:
  - crossing pulses every 8 valid samples.
  - Second crossing gives meas_valid with period=8, peak=255, trough=0, amplitude=255.
  - locked=1 after the 4th crossing (LOCK_COUNT=2).
- Hysteresis: samples 125,131,125,131 (inside ±4 band) -> no crossing. Then 120,132 -> one crossing pulse.
- Period drift: locked on period 8, then one period of 12 -> meas_valid with period=12, locked drops to 0, state MEASURE. Return to 8 -> relock after 2 more matching periods.
- Timeout: locked, then constant sample 200 for 2^16 valid samples -> locked=0, period=0, no further meas_valid until two new crossings.
- Loopback: drive from the sine generator with phaseStep=2, gated valid every other clock -> period constant, within TOL; locked asserts; amplitude matches table max minus min; sample_index wraps at each crossing.
